ex_mem_pipe_reg: RTL

//  Parametrised EX->MEM pipeline register for the 19-bit pipelined CPU.
//  - Supersedes the fixed free-running EX/MEM latch.
//  - Adds a valid/ready handshake, back-pressure stall, synchronous flush and control-bubble insertion.
//  - Adds a saturating stall counter for performance debug.
//  - Sits between the ALU (EX) and data memory (MEM) stages.

---
 rtl/ex_mem_pipe_reg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, flush, bubble insertion and a saturating stall counter.
// Define EX_MEM_SKID_EN to add a one-entry skid buffer, which gives a registered in_ready.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned RD_W   = 3,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_out,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_out,
  output logic [DATA_W-1:0] out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              in_xfer;
  logic              out_xfer;
  logic              load_main;
  logic [CTRL_W-1:0] src_ctrl;
  logic [DATA_W-1:0] src_out;
  logic [DATA_W-1:0] src_wdata;
  logic [RD_W-1:0]   src_rd;

  assign out_xfer = out_valid & out_ready;
  assign in_xfer  = in_valid & in_ready;

`ifdef EX_MEM_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_out;
  logic [DATA_W-1:0] skid_wdata;
  logic [RD_W-1:0]   skid_rd;

  // skid_valid is a flop, so in_ready has no combinational path from out_ready
  assign in_ready  = ~skid_valid;
  assign skid_load = in_xfer & out_valid & ~out_ready;

  always_comb begin
    load_main = 1'b0;
    src_ctrl  = in_ctrl;
    src_out   = in_out;
    src_wdata = in_wdata;
    src_rd    = in_rd;
    if (skid_valid) begin
      // the older skid entry refills the main register before any new input
      load_main = out_xfer;
      src_ctrl  = skid_ctrl;
      src_out   = skid_out;
      src_wdata = skid_wdata;
      src_rd    = skid_rd;
    end else begin
      load_main = in_xfer & (~out_valid | out_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      skid_valid <= 1'b0;
    end else if (skid_load) begin
      skid_valid <= 1'b1;
    end else if (out_xfer) begin
      skid_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_ctrl  <= in_ctrl;
      skid_out   <= in_out;
      skid_wdata <= in_wdata;
      skid_rd    <= in_rd;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_comb begin
    load_main = in_xfer;
    src_ctrl  = in_ctrl;
    src_out   = in_out;
    src_wdata = in_wdata;
    src_rd    = in_rd;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_out   <= '0;
      out_wdata <= '0;
      out_rd    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (load_main) begin
      out_valid <= 1'b1;
      out_ctrl  <= src_ctrl;
      out_out   <= src_out;
      out_wdata <= src_wdata;
      out_rd    <= src_rd;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
